// File: rtl/tour_cmd_sched.sv
// Command scheduler: UART pass-through while idle; during a knight's tour it
// replays each stored move as a vertical leg then a horizontal leg with fanfare.
module tour_cmd_sched #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] WAIT_H = 3'd4;

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  typedef struct packed {
    logic [7:0] heading;
    logic [3:0] squares;
  } leg_t;

  logic [2:0] state;
  leg_t       v_leg, h_leg;
  logic       last_move;

  assign last_move = (mv_indx == 5'(NUM_MOVES - 1));

  // Lowest set bit wins; move is stable for the whole move, so the decoded
  // legs stay stable through the matching send_resp.
  always_comb begin
    v_leg = '0;
    h_leg = '0;
    casez (move)
      8'b???????1: begin v_leg = '{HD_N, 4'd2}; h_leg = '{HD_W, 4'd1}; end
      8'b??????10: begin v_leg = '{HD_N, 4'd2}; h_leg = '{HD_E, 4'd1}; end
      8'b?????100: begin v_leg = '{HD_N, 4'd1}; h_leg = '{HD_W, 4'd2}; end
      8'b????1000: begin v_leg = '{HD_S, 4'd1}; h_leg = '{HD_W, 4'd2}; end
      8'b???10000: begin v_leg = '{HD_S, 4'd2}; h_leg = '{HD_W, 4'd1}; end
      8'b??100000: begin v_leg = '{HD_S, 4'd2}; h_leg = '{HD_E, 4'd1}; end
      8'b?1000000: begin v_leg = '{HD_S, 4'd1}; h_leg = '{HD_E, 4'd2}; end
      8'b10000000: begin v_leg = '{HD_N, 4'd1}; h_leg = '{HD_E, 4'd2}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      case (state)
        IDLE:
          if (start_tour) begin
            state   <= VERT;
            mv_indx <= '0;
          end
        VERT:
          if (move == 8'h00) begin
            state   <= IDLE;
            mv_indx <= '0;
          end else if (clr_cmd_rdy) begin
            state <= WAIT_V;
          end
        WAIT_V:
          if (send_resp) state <= HORZ;
        HORZ:
          if (clr_cmd_rdy) state <= WAIT_H;
        WAIT_H:
          if (send_resp) begin
            if (last_move) begin
              state   <= IDLE;
              mv_indx <= '0;
            end else begin
              state   <= VERT;
              mv_indx <= mv_indx + 5'd1;
            end
          end
        default: begin
          state   <= IDLE;
          mv_indx <= '0;
        end
      endcase
    end
  end

  // Outside IDLE the UART handshake is frozen so its command stays pending.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = 8'hA5;
    case (state)
      VERT: begin
        cmd              = {4'b0010, v_leg};
        cmd_rdy          = |move;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
      end
      WAIT_V: begin
        cmd              = {4'b0010, v_leg};
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
      end
      HORZ: begin
        cmd              = {4'b0011, h_leg};
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
      end
      WAIT_H: begin
        cmd              = {4'b0011, h_leg};
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = last_move ? 8'hA5 : 8'h5A;
      end
      default: ;
    endcase
  end

endmodule
